// File: rtl/demux_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_sched_pkg
//  Purpose  : Shared types and constants for the 1-to-4 demux scheduler.
//             Holds the two-state holding-stage encoding and the lane
//             geometry used by the top and its lane counters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package demux_sched_pkg;

    localparam int NUM_LANES      = 4;
    localparam int LANE_SEL_WIDTH = 2;

    // Holding-stage state: EMPTY = no word held, FULL = word offered to a lane
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage : demux_sched_pkg
`default_nettype wire

// File: rtl/demux_sched_lane_counter.sv
`default_nettype none
// ============================================================================
//  Module   : demux_sched_lane_counter
//  Purpose  : Free-running wrapping transfer counter with increment enable.
//             Wraps silently modulo 2^COUNT_WIDTH.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset (count -> 0)
//             inc   - increment enable, one count per cycle when high
//             count - current count value
//  Revision : 1.0 - initial release
// ============================================================================
module demux_sched_lane_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : demux_sched_lane_counter
`default_nettype wire

// File: rtl/demux_1_to_4_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_to_4_scheduler
//  Purpose  : Round-robin scheduler for a 1-to-4 demux datapath. One word is
//             held in a registered stage and offered to the currently
//             selected lane; the selection rotates by one on every transfer.
//             Ingress stalls while the selected lane is not ready.
//  Config   : DEMUX_SCHED_SKIP_EN - when defined, a lane that stays not-ready
//             for STALL_LIMIT consecutive held cycles is skipped and the
//             skip is counted on skip_count.
//  Ports    : clk, rst_n           - clock, asynchronous active-low reset
//             in_valid/in_data     - ingress word and valid
//             in_ready             - ingress may accept this cycle
//             out_ready[3:0]       - per-lane consumer ready
//             out_valid[3:0]       - one-hot lane valid
//             out_data             - held word, broadcast to all lanes
//             select_lines[1:0]    - currently selected lane
//             sent_count           - per-lane transfer counts, lane i at
//                                    [i*COUNT_WIDTH +: COUNT_WIDTH]
//             skip_count           - skipped lanes (DEMUX_SCHED_SKIP_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
module demux_1_to_4_scheduler
    import demux_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16,
    parameter int STALL_LIMIT = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    input  logic [NUM_LANES-1:0]             out_ready,
    output logic [NUM_LANES-1:0]             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [LANE_SEL_WIDTH-1:0]        select_lines,
`ifdef DEMUX_SCHED_SKIP_EN
    output logic [COUNT_WIDTH-1:0]           skip_count,
`endif
    output logic [NUM_LANES*COUNT_WIDTH-1:0] sent_count
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [LANE_SEL_WIDTH-1:0] r_sel;
    logic                      w_fire;
    logic                      w_accept;
    logic                      w_skip;

    // Transfer to the selected lane; in_ready is one gate level off out_ready
    assign w_fire   = (r_state == ST_FULL) && out_ready[r_sel];
    assign in_ready = (r_state == ST_EMPTY) || w_fire;
    assign w_accept = in_valid && in_ready;

`ifdef DEMUX_SCHED_SKIP_EN
    localparam int c_stall_w = $clog2(STALL_LIMIT + 1);

    logic [c_stall_w-1:0] r_stall;
    logic                 w_stalled;

    assign w_stalled = (r_state == ST_FULL) && !out_ready[r_sel];
    // Skip on the cycle that would bring the stall run up to STALL_LIMIT
    assign w_skip    = w_stalled && (r_stall == c_stall_w'(STALL_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_stalled && !w_skip) begin
            r_stall <= r_stall + 1'b1;
        end else begin
            r_stall <= '0;
        end
    end

    demux_sched_lane_counter #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_skip_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_skip),
        .count (skip_count)
    );
`else
    logic w_unused_stall_limit;

    assign w_skip               = 1'b0;
    assign w_unused_stall_limit = (STALL_LIMIT != 0);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept)            w_state_nxt = ST_FULL;
            ST_FULL:  if (w_fire && !w_accept) w_state_nxt = ST_EMPTY;
            default:                           w_state_nxt = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = '0;
        if (r_state == ST_FULL) begin
            out_valid[r_sel] = 1'b1;
        end
    end

    // Held word and lane selection. out_data only moves on accept so it
    // keeps the last word while EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= '0;
        end else begin
            if (w_accept) begin
                r_data <= in_data;
            end
            if (w_fire || w_skip) begin
                r_sel <= r_sel + 2'd1;
            end
        end
    end

    assign out_data     = r_data;
    assign select_lines = r_sel;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_sched_lane_counter #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_lane_counter (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (w_fire && (r_sel == LANE_SEL_WIDTH'(i))),
            .count (sent_count[i*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

endmodule : demux_1_to_4_scheduler
`default_nettype wire
